// File: rtl/draw_track_background.sv
// Two-stage VGA background generator: a border test pattern or a scrolling race track,
// with the incoming timing delayed to stay aligned with rgb_out.
module draw_track_background #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned ROAD_LEFT   = 200,
  parameter int unsigned ROAD_RIGHT  = 600,
  parameter int unsigned EDGE_W      = 10,
  parameter int unsigned LINE_W      = 10,
  parameter int unsigned DASH_LEN    = 40,
  parameter int unsigned DASH_PERIOD = 80,
  parameter int unsigned SPEED_W     = 4,
  parameter logic [11:0] BG_COLOR    = 12'h110,
  parameter logic [11:0] ROAD_COLOR  = 12'h666,
  parameter logic [11:0] EDGE_COLOR  = 12'hf45,
  parameter logic [11:0] MARK_COLOR  = 12'hfff
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [10:0]        hcount_in,
  input  logic [10:0]        vcount_in,
  input  logic               hsync_in,
  input  logic               hblnk_in,
  input  logic               vsync_in,
  input  logic               vblnk_in,
  input  logic               mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  output logic [10:0]        hcount_out,
  output logic [10:0]        vcount_out,
  output logic               hsync_out,
  output logic               hblnk_out,
  output logic               vsync_out,
  output logic               vblnk_out,
  output logic [11:0]        rgb_out,
  output logic               frame_tick
);

  localparam int unsigned PH_W   = $clog2(DASH_PERIOD);
  localparam int unsigned SUM_W  = PH_W + 1;
  localparam int unsigned TM_W   = 26;
  localparam int unsigned CENTER = (ROAD_LEFT + ROAD_RIGHT) / 2;
  localparam int unsigned MARK_L = CENTER - LINE_W / 2;
  localparam int unsigned MARK_R = CENTER + LINE_W / 2;

  localparam logic [3:0] RG_BLANK  = 4'd0;
  localparam logic [3:0] RG_TOP    = 4'd1;
  localparam logic [3:0] RG_BOTTOM = 4'd2;
  localparam logic [3:0] RG_LEFT   = 4'd3;
  localparam logic [3:0] RG_RIGHT  = 4'd4;
  localparam logic [3:0] RG_BG     = 4'd5;
  localparam logic [3:0] RG_EDGE   = 4'd6;
  localparam logic [3:0] RG_MARK   = 4'd7;
  localparam logic [3:0] RG_ROAD   = 4'd8;

  logic            vblnk_prev_q, vblnk_prev_d;
  logic            hblnk_prev_q, hblnk_prev_d;
  logic [PH_W-1:0] offset_q, offset_d;
  logic [PH_W-1:0] line_phase_q, line_phase_d;
  logic [TM_W-1:0] timing1_q, timing1_d;
  logic [3:0]      region1_q, region1_d;
  logic [TM_W-1:0] timing2_q, timing2_d;
  logic [11:0]     rgb2_q, rgb2_d;
  logic            frame_tick_q, frame_tick_d;

  logic             frame_event, line_event;
  logic [SUM_W-1:0] off_sum, off_wrap;

  always_comb begin
    vblnk_prev_d = vblnk_in;
    hblnk_prev_d = hblnk_in;
    offset_d     = offset_q;
    line_phase_d = line_phase_q;
    timing1_d    = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};
    region1_d    = RG_ROAD;
    timing2_d    = timing1_q;
    rgb2_d       = 12'h000;

    frame_event  = vblnk_in && !vblnk_prev_q;
    line_event   = hblnk_in && !hblnk_prev_q && !vblnk_in;
    frame_tick_d = frame_event;

    // Scroll offset advances once per frame, modulo the dash period
    off_sum  = SUM_W'(offset_q) + SUM_W'(speed);
    off_wrap = (off_sum >= SUM_W'(DASH_PERIOD)) ? off_sum - SUM_W'(DASH_PERIOD) : off_sum;
    if (frame_event && !pause) offset_d = PH_W'(off_wrap);

    // Phase is rebased to -offset at frame start so line v lands on (v - offset)
    if (frame_event) begin
      line_phase_d = (offset_d == '0) ? '0 : PH_W'(DASH_PERIOD) - offset_d;
    end else if (line_event) begin
      line_phase_d = (line_phase_q == PH_W'(DASH_PERIOD - 1)) ? '0 : line_phase_q + PH_W'(1);
    end

    if (hblnk_in || vblnk_in) begin
      region1_d = RG_BLANK;
    end else if (!mode) begin
      if (vcount_in == 11'd0)                       region1_d = RG_TOP;
      else if (vcount_in == 11'(V_ACTIVE - 1))      region1_d = RG_BOTTOM;
      else if (hcount_in == 11'd0)                  region1_d = RG_LEFT;
      else if (hcount_in == 11'(H_ACTIVE - 1))      region1_d = RG_RIGHT;
      else                                          region1_d = RG_BG;
    end else if (hcount_in < 11'(ROAD_LEFT) || hcount_in >= 11'(ROAD_RIGHT)) begin
      region1_d = RG_BG;
    end else if (hcount_in < 11'(ROAD_LEFT + EDGE_W) || hcount_in >= 11'(ROAD_RIGHT - EDGE_W)) begin
      region1_d = RG_EDGE;
    end else if (hcount_in >= 11'(MARK_L) && hcount_in < 11'(MARK_R)
                 && line_phase_q < PH_W'(DASH_LEN)) begin
      region1_d = RG_MARK;
    end

    case (region1_q)
      RG_TOP:    rgb2_d = 12'hff0;
      RG_BOTTOM: rgb2_d = 12'hf00;
      RG_LEFT:   rgb2_d = 12'h0f0;
      RG_RIGHT:  rgb2_d = 12'h00f;
      RG_BG:     rgb2_d = BG_COLOR;
      RG_EDGE:   rgb2_d = EDGE_COLOR;
      RG_MARK:   rgb2_d = MARK_COLOR;
      RG_ROAD:   rgb2_d = ROAD_COLOR;
      default:   rgb2_d = 12'h000;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      hblnk_prev_q <= 1'b0;
      offset_q     <= '0;
      line_phase_q <= '0;
      timing1_q    <= '0;
      region1_q    <= RG_BLANK;
      timing2_q    <= '0;
      rgb2_q       <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      hblnk_prev_q <= hblnk_prev_d;
      offset_q     <= offset_d;
      line_phase_q <= line_phase_d;
      timing1_q    <= timing1_d;
      region1_q    <= region1_d;
      timing2_q    <= timing2_d;
      rgb2_q       <= rgb2_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} = timing2_q;
  assign rgb_out    = rgb2_q;
  assign frame_tick = frame_tick_q;

endmodule
